// File: rtl/softex_pkg.sv
// Shared types and constants for the softmax normalisation stage.
package softex_pkg;

  localparam int unsigned NUM_REGS_NORM_MUL = 32'd3;
  localparam int unsigned NORM_LEN_W        = 32'd16;

  typedef enum logic [2:0] {
    NORM_IDLE       = 3'd0,
    NORM_WAIT_RECIP = 3'd1,
    NORM_NORM       = 3'd2,
    NORM_DRAIN      = 3'd3,
    NORM_DONE       = 3'd4
  } norm_state_t;

  typedef struct packed {
    logic                  start;
    logic [NORM_LEN_W-1:0] length;
  } norm_ctrl_t;

  typedef struct packed {
    logic busy;
    logic done;
  } norm_flags_t;

  function automatic norm_flags_t norm_state_flags(input norm_state_t state);
    norm_flags_t flags;
    flags.busy = (state != NORM_IDLE);
    flags.done = (state == NORM_DONE);
    return flags;
  endfunction

endpackage

// File: rtl/softex_norm_ctrl_if.sv
// Job control, reciprocal and score/result stream handshakes of the normalisation controller.
interface softex_norm_ctrl_if #(
  parameter int unsigned LEN_W = 32'd16,
  parameter int unsigned FPW   = 32'd16
);

  logic             start_i;
  logic [LEN_W-1:0] length_i;
  logic             recip_valid_i;
  logic [FPW-1:0]   recip_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic             pipe_en_o;
  logic [FPW-1:0]   scale_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             out_last_o;
  logic             busy_o;
  logic             done_o;

  // The controller side.
  modport slave (
    input  start_i, length_i, recip_valid_i, recip_i, in_valid_i, out_ready_i,
    output in_ready_o, pipe_en_o, scale_o, out_valid_o, out_last_o, busy_o, done_o
  );

  // The environment driving jobs and consuming results.
  modport master (
    output start_i, length_i, recip_valid_i, recip_i, in_valid_i, out_ready_i,
    input  in_ready_o, pipe_en_o, scale_o, out_valid_o, out_last_o, busy_o, done_o
  );

endinterface

// File: rtl/softex_norm_vld_pipe.sv
// Valid tracker mirroring the multiplier pipeline; the whole chain advances on pipe_en_o.
module softex_norm_vld_pipe #(
  parameter int unsigned MUL_REGS = 32'd3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic in_fire_i,
  input  logic out_ready_i,
  output logic pipe_en_o,
  output logic out_valid_o
);

  logic [MUL_REGS-1:0] vld_r;
  logic [MUL_REGS-1:0] vld_shift_s;

  generate
    if (MUL_REGS == 32'd1) begin : g_single
      assign vld_shift_s = in_fire_i;
    end else begin : g_multi
      assign vld_shift_s = {vld_r[MUL_REGS-2:0], in_fire_i};
    end
  endgenerate

  // A full last stage with no taker freezes every stage, bubbles included.
  assign pipe_en_o   = ~vld_r[MUL_REGS-1] | out_ready_i;
  assign out_valid_o = vld_r[MUL_REGS-1];

  // Valid shift register, flushed by the soft clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_r <= {MUL_REGS{1'b0}};
    end else if (clear_i) begin
      vld_r <= {MUL_REGS{1'b0}};
    end else if (pipe_en_o) begin
      vld_r <= vld_shift_s;
    end else begin
      vld_r <= vld_r;
    end
  end

endmodule

// File: rtl/softex_norm_ctrl.sv
// Normalisation-stage controller: holds the softmax reciprocal and schedules
// score x reciprocal through the external fixed-latency multipliers.
module softex_norm_ctrl
  import softex_pkg::*;
#(
  parameter int unsigned MUL_REGS = NUM_REGS_NORM_MUL,
  parameter int unsigned LEN_W    = 32'd16,
  parameter int unsigned FPW      = 32'd16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  softex_norm_ctrl_if.slave  bus
);

  localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  norm_state_t      state_r;
  norm_state_t      state_s;
  norm_flags_t      flags_s;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] issue_cnt_r;
  logic [LEN_W-1:0] out_cnt_r;
  logic [FPW-1:0]   recip_r;
  logic             recip_loaded_r;

  logic pipe_en_s;
  logic out_valid_s;
  logic in_ready_s;
  logic in_fire_s;
  logic out_fire_s;
  logic issue_last_s;
  logic out_final_s;
  logic recip_cap_s;

  softex_norm_vld_pipe #(
    .MUL_REGS (MUL_REGS)
  ) u_vld_pipe (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .in_fire_i   (in_fire_s),
    .out_ready_i (bus.out_ready_i),
    .pipe_en_o   (pipe_en_s),
    .out_valid_o (out_valid_s)
  );

  assign in_ready_s   = (state_r == NORM_NORM) & pipe_en_s & (issue_cnt_r != len_r);
  assign in_fire_s    = in_ready_s & bus.in_valid_i;
  assign out_fire_s   = out_valid_s & bus.out_ready_i;
  // Counters stay below len_r while they are compared, so +1 cannot wrap here.
  assign issue_last_s = ((issue_cnt_r + CNT_ONE) == len_r);
  assign out_final_s  = ((out_cnt_r + CNT_ONE) == len_r);

  // The scale is only replaced outside an active job so it stays stable per job.
  always_comb begin
    recip_cap_s = 1'b0;
    case (state_r)
      NORM_IDLE, NORM_WAIT_RECIP, NORM_DONE: recip_cap_s = bus.recip_valid_i;
      NORM_NORM, NORM_DRAIN:                 recip_cap_s = 1'b0;
      default:                               recip_cap_s = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      NORM_IDLE: begin
        if (bus.start_i) begin
          if (bus.length_i == CNT_ZERO) begin
            state_s = NORM_DONE;
          end else if (recip_loaded_r | bus.recip_valid_i) begin
            state_s = NORM_NORM;
          end else begin
            state_s = NORM_WAIT_RECIP;
          end
        end else begin
          state_s = NORM_IDLE;
        end
      end
      NORM_WAIT_RECIP: begin
        if (bus.recip_valid_i) begin
          state_s = NORM_NORM;
        end else begin
          state_s = NORM_WAIT_RECIP;
        end
      end
      NORM_NORM: begin
        if (in_fire_s & issue_last_s) begin
          state_s = NORM_DRAIN;
        end else begin
          state_s = NORM_NORM;
        end
      end
      NORM_DRAIN: begin
        if (out_fire_s & out_final_s) begin
          state_s = NORM_DONE;
        end else begin
          state_s = NORM_DRAIN;
        end
      end
      NORM_DONE: state_s = NORM_IDLE;
      default:   state_s = NORM_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= NORM_IDLE;
    end else if (clear_i) begin
      state_r <= NORM_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Job length, latched on an accepted start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_r <= CNT_ZERO;
    end else if (clear_i) begin
      len_r <= CNT_ZERO;
    end else if ((state_r == NORM_IDLE) && bus.start_i) begin
      len_r <= bus.length_i;
    end else begin
      len_r <= len_r;
    end
  end

  // Issue and output counters, reset at the end of every job.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_cnt_r <= CNT_ZERO;
      out_cnt_r   <= CNT_ZERO;
    end else if (clear_i || (state_r == NORM_DONE)) begin
      issue_cnt_r <= CNT_ZERO;
      out_cnt_r   <= CNT_ZERO;
    end else begin
      issue_cnt_r <= in_fire_s  ? (issue_cnt_r + CNT_ONE) : issue_cnt_r;
      out_cnt_r   <= out_fire_s ? (out_cnt_r + CNT_ONE)   : out_cnt_r;
    end
  end

  // Reciprocal holding register; a capture in DONE re-arms it for the next job.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      recip_r        <= {FPW{1'b0}};
      recip_loaded_r <= 1'b0;
    end else if (clear_i) begin
      recip_r        <= recip_r;
      recip_loaded_r <= 1'b0;
    end else if (recip_cap_s) begin
      recip_r        <= bus.recip_i;
      recip_loaded_r <= 1'b1;
    end else if (state_r == NORM_DONE) begin
      recip_r        <= recip_r;
      recip_loaded_r <= 1'b0;
    end else begin
      recip_r        <= recip_r;
      recip_loaded_r <= recip_loaded_r;
    end
  end

  assign flags_s = norm_state_flags(state_r);

  assign bus.in_ready_o  = in_ready_s;
  assign bus.pipe_en_o   = pipe_en_s;
  assign bus.scale_o     = recip_r;
  assign bus.out_valid_o = out_valid_s;
  assign bus.out_last_o  = out_valid_s & (out_cnt_r == (len_r - CNT_ONE));
  assign bus.busy_o      = flags_s.busy;
  assign bus.done_o      = flags_s.done;

endmodule

// File: tb/tb_softex_norm_ctrl.sv
// Bench for softex_norm_ctrl: directed job scenarios plus random jobs, all cycles
// checked against a transaction-level model of jobs, reciprocal and in-flight latency.
module tb_softex_norm_ctrl;

  localparam int MUL = 3;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic clear_i;

  softex_norm_ctrl_if #(.LEN_W(16), .FPW(16)) bus ();

  softex_norm_ctrl #(
    .MUL_REGS (MUL),
    .LEN_W    (16),
    .FPW      (16)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: job bookkeeping plus remaining travel time of each in-flight element.
  bit          m_act = 1'b0;
  bit          m_go = 1'b0;
  bit          m_done = 1'b0;
  bit          m_loaded = 1'b0;
  int          m_len = 0;
  int          m_iss = 0;
  int          m_del = 0;
  logic [15:0] m_recip = 16'h0000;
  int          lat_q[$];

  int n_out_obs, n_done_obs, first_acc_cyc, first_out_cyc;

  task automatic tick();
    logic [5:0]  e_vec;
    logic [5:0]  o_vec;
    logic        e_ov, e_en, e_ir, e_ol;
    bit          in_hs, out_hs, cap, was_done;
    #2;
    e_ov  = (lat_q.size() > 0) && (lat_q[0] == 0);
    e_en  = !e_ov || bus.out_ready_i;
    e_ir  = m_act && m_go && (m_iss < m_len) && e_en;
    e_ol  = e_ov && (m_del == m_len - 1);
    e_vec = {e_ov, e_en, e_ir, e_ol, (m_act || m_done), m_done};
    o_vec = {bus.out_valid_o, bus.pipe_en_o, bus.in_ready_o, bus.out_last_o, bus.busy_o, bus.done_o};
    n_checks++;
    assert (o_vec === e_vec) else begin
      n_errors++;
      $error("FAIL ctrl cyc=%0d {ov,en,ir,last,busy,done} got %b expected %b", cyc, o_vec, e_vec);
    end
    n_checks++;
    assert (bus.scale_o === m_recip) else begin
      n_errors++;
      $error("FAIL scale cyc=%0d got %h expected %h", cyc, bus.scale_o, m_recip);
    end
    if (bus.in_valid_i && bus.in_ready_o && first_acc_cyc < 0) first_acc_cyc = cyc;
    if (bus.out_valid_o && first_out_cyc < 0) first_out_cyc = cyc;
    if (bus.out_valid_o && bus.out_ready_i) n_out_obs++;
    if (bus.done_o) n_done_obs++;

    in_hs  = e_ir && bus.in_valid_i;
    out_hs = e_ov && bus.out_ready_i;
    if (clear_i) begin
      m_act = 1'b0; m_go = 1'b0; m_done = 1'b0; m_loaded = 1'b0;
      m_iss = 0; m_del = 0;
      lat_q.delete();
    end else begin
      cap      = bus.recip_valid_i && (!m_act || !m_go);
      was_done = m_done;
      if (e_en) begin
        if (out_hs) void'(lat_q.pop_front());
        for (int i = 0; i < lat_q.size(); i++) if (lat_q[i] > 0) lat_q[i] = lat_q[i] - 1;
        if (in_hs) lat_q.push_back(MUL - 1);
      end
      if (was_done) begin
        m_done = 1'b0;
        m_loaded = 1'b0;
      end
      if (cap) begin
        m_recip = bus.recip_i;
        m_loaded = 1'b1;
      end
      if (!m_act && !was_done && bus.start_i) begin
        m_len = int'(bus.length_i);
        m_iss = 0;
        m_del = 0;
        if (m_len == 0) m_done = 1'b1;
        else begin
          m_act = 1'b1;
          m_go  = m_loaded;
        end
      end else if (m_act && !m_go && bus.recip_valid_i) begin
        m_go = 1'b1;
      end
      if (in_hs) m_iss++;
      if (out_hs) begin
        m_del++;
        if (m_del == m_len) begin
          m_act = 1'b0; m_go = 1'b0; m_done = 1'b1;
        end
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic begin_job();
    n_out_obs = 0; n_done_obs = 0; first_acc_cyc = -1; first_out_cyc = -1;
  endtask

  task automatic run_job(input string tag, input int budget);
    int k = 0;
    while ((m_act || m_done) && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    assert (!(m_act || m_done)) else begin
      n_errors++;
      $error("FAIL %s_timeout job still open after %0d cycles, expected completion", tag, budget);
    end
  endtask

  task automatic end_job(input string tag, input int exp_n);
    n_checks++;
    assert (n_out_obs == exp_n) else begin
      n_errors++;
      $error("FAIL %s_count got %0d outputs expected %0d", tag, n_out_obs, exp_n);
    end
    n_checks++;
    assert (n_done_obs == 1) else begin
      n_errors++;
      $error("FAIL %s_done got %0d done pulses expected 1", tag, n_done_obs);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst_ni = 1'b0; clear_i = 1'b0;
    bus.start_i = 1'b0; bus.length_i = 16'd0; bus.recip_valid_i = 1'b0; bus.recip_i = 16'h0000;
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    #3;
    n_checks++;
    assert ({bus.out_valid_o, bus.in_ready_o, bus.out_last_o, bus.busy_o, bus.done_o, bus.scale_o} === 21'd0) else begin
      n_errors++;
      $error("FAIL reset got ov=%b ir=%b last=%b busy=%b done=%b scale=%h expected all zero",
             bus.out_valid_o, bus.in_ready_o, bus.out_last_o, bus.busy_o, bus.done_o, bus.scale_o);
    end
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Basic job.
    bus.recip_valid_i = 1'b1; bus.recip_i = 16'h3C00;
    tick();
    bus.recip_valid_i = 1'b0;
    bus.start_i = 1'b1; bus.length_i = 16'd4; bus.in_valid_i = 1'b1; bus.out_ready_i = 1'b1;
    begin_job();
    tick();
    bus.start_i = 1'b0;
    run_job("basic", 30);
    end_job("basic", 4);
    n_checks++;
    assert (first_out_cyc - first_acc_cyc == MUL) else begin
      n_errors++;
      $error("FAIL basic_latency got %0d cycles expected %0d", first_out_cyc - first_acc_cyc, MUL);
    end
    n_checks++;
    assert (bus.scale_o === 16'h3C00) else begin
      n_errors++;
      $error("FAIL basic_scale got %h expected 3c00", bus.scale_o);
    end

    // Late reciprocal.
    bus.start_i = 1'b1; bus.length_i = 16'd2;
    begin_job();
    tick();
    bus.start_i = 1'b0;
    repeat (10) tick();
    n_checks++;
    assert ({bus.busy_o, bus.in_ready_o} === 2'b10) else begin
      n_errors++;
      $error("FAIL late_wait got busy=%b ir=%b expected busy=1 ir=0", bus.busy_o, bus.in_ready_o);
    end
    bus.recip_valid_i = 1'b1; bus.recip_i = 16'h4000;
    tick();
    bus.recip_valid_i = 1'b0;
    run_job("late", 30);
    end_job("late", 2);

    // Back-pressure, with reciprocal arriving together with start.
    bus.start_i = 1'b1; bus.length_i = 16'd5; bus.recip_valid_i = 1'b1; bus.recip_i = 16'h3800;
    begin_job();
    tick();
    bus.start_i = 1'b0; bus.recip_valid_i = 1'b0;
    k = 0;
    while (!(lat_q.size() > 0 && lat_q[0] == 0) && k < 20) begin
      tick();
      k++;
    end
    bus.out_ready_i = 1'b0;
    repeat (4) begin
      #2;
      n_checks++;
      assert ({bus.pipe_en_o, bus.in_ready_o, bus.out_valid_o} === 3'b001) else begin
        n_errors++;
        $error("FAIL stall got en=%b ir=%b ov=%b expected en=0 ir=0 ov=1",
               bus.pipe_en_o, bus.in_ready_o, bus.out_valid_o);
      end
      tick();
    end
    bus.out_ready_i = 1'b1;
    run_job("bp", 40);
    end_job("bp", 5);

    // Zero length.
    bus.start_i = 1'b1; bus.length_i = 16'd0;
    begin_job();
    tick();
    bus.start_i = 1'b0;
    n_checks++;
    assert (bus.done_o === 1'b1) else begin
      n_errors++;
      $error("FAIL zero_done got %b expected 1", bus.done_o);
    end
    run_job("zero", 5);
    end_job("zero", 0);

    // Clear mid-job.
    bus.start_i = 1'b1; bus.length_i = 16'd8; bus.recip_valid_i = 1'b1; bus.recip_i = 16'h3C00;
    tick();
    bus.start_i = 1'b0; bus.recip_valid_i = 1'b0;
    k = 0;
    while (m_iss < 3 && k < 20) begin
      tick();
      k++;
    end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    n_checks++;
    assert ({bus.busy_o, bus.out_valid_o, bus.done_o} === 3'b000) else begin
      n_errors++;
      $error("FAIL clear got busy=%b ov=%b done=%b expected 000", bus.busy_o, bus.out_valid_o, bus.done_o);
    end
    bus.start_i = 1'b1; bus.length_i = 16'd2;
    begin_job();
    tick();
    bus.start_i = 1'b0;
    repeat (3) tick();
    n_checks++;
    assert ({bus.busy_o, bus.in_ready_o} === 2'b10) else begin
      n_errors++;
      $error("FAIL clear_wait got busy=%b ir=%b expected busy=1 ir=0", bus.busy_o, bus.in_ready_o);
    end
    bus.recip_valid_i = 1'b1; bus.recip_i = 16'h4400;
    tick();
    bus.recip_valid_i = 1'b0;
    run_job("clear", 30);
    end_job("clear", 2);

    // Reciprocal pulse during a job must not disturb the scale.
    bus.start_i = 1'b1; bus.length_i = 16'd6; bus.recip_valid_i = 1'b1; bus.recip_i = 16'h3C00;
    begin_job();
    tick();
    bus.start_i = 1'b0; bus.recip_valid_i = 1'b0;
    repeat (2) tick();
    bus.recip_valid_i = 1'b1; bus.recip_i = 16'h1234;
    tick();
    bus.recip_valid_i = 1'b0;
    n_checks++;
    assert (bus.scale_o === 16'h3C00) else begin
      n_errors++;
      $error("FAIL hold_scale got %h expected 3c00", bus.scale_o);
    end
    run_job("hold", 40);
    end_job("hold", 6);

    // Random jobs with random flow control, stray starts, reciprocal pulses and rare clears.
    for (int j = 0; j < 25; j++) begin
      bus.start_i = 1'b1;
      bus.length_i = 16'($urandom_range(0, 10));
      bus.recip_valid_i = 1'($urandom_range(0, 1));
      bus.recip_i = 16'($urandom);
      bus.in_valid_i = 1'($urandom_range(0, 1));
      bus.out_ready_i = 1'($urandom_range(0, 1));
      tick();
      k = 0;
      while ((m_act || m_done) && k < 300) begin
        bus.start_i = ($urandom_range(0, 7) == 0);
        bus.in_valid_i = ($urandom_range(0, 3) != 0);
        bus.out_ready_i = ($urandom_range(0, 3) != 0);
        bus.recip_valid_i = m_done ? 1'b0 : ($urandom_range(0, 7) == 0);
        bus.recip_i = 16'($urandom);
        clear_i = ($urandom_range(0, 199) == 0);
        tick();
        k++;
      end
      clear_i = 1'b0; bus.start_i = 1'b0; bus.recip_valid_i = 1'b0;
      n_checks++;
      assert (!(m_act || m_done)) else begin
        n_errors++;
        $error("FAIL rand_timeout job %0d still open, expected completion", j);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
